// File: rtl/square_motion_ctrl.sv
// rtl/square_motion_ctrl.sv - per-frame square position sequencer with edge bounce, updated in vblank
// Optional: `define SQUARE_MOTION_DRAW_EN adds the registered q_draw coverage output.
module square_motion_ctrl #(
  parameter int CORDW     = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int Q_SIZE    = 32,
  parameter int SPEED     = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             enable,
  output logic [CORDW-1:0] qx,
  output logic [CORDW-1:0] qy,
  output logic             dir_x,
  output logic             dir_y,
  output logic             bounce,
  output logic             busy
`ifdef SQUARE_MOTION_DRAW_EN
  ,
  output logic             q_draw
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC_X = 2'd1;
  localparam logic [1:0] S_CALC_Y = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [CORDW:0]   XMAX     = (CORDW+1)'(H_RES - Q_SIZE);
  localparam logic [CORDW:0]   YMAX     = (CORDW+1)'(V_RES - Q_SIZE);
  localparam logic [CORDW:0]   STEP     = (CORDW+1)'(SPEED);
  localparam logic [7:0]       DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [CORDW-1:0] TICK_Y   = CORDW'(V_RES);

  logic [1:0]       state_q, state_d;
  logic             tick_q;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [CORDW-1:0] qx_q, qx_d, qy_q, qy_d, nx_q, nx_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic             flip_x_q, flip_x_d, flip_y;
  logic             bounce_q, bounce_d;

  // Moving +: clamp at mx once the step would reach it; moving -: clamp at 0.
  function automatic logic [CORDW:0] step_pos(input logic [CORDW:0] p, input logic d,
                                              input logic [CORDW:0] mx);
    if (!d) return (p + STEP >= mx) ? mx : p + STEP;
    return (p <= STEP) ? '0 : p - STEP;
  endfunction

  function automatic logic step_flip(input logic [CORDW:0] p, input logic d,
                                     input logic [CORDW:0] mx);
    if (!d) return (p + STEP >= mx);
    return (p <= STEP);
  endfunction

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    qx_d        = qx_q;
    qy_d        = qy_q;
    nx_d        = nx_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    flip_x_d    = flip_x_q;
    flip_y      = 1'b0;
    bounce_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_q && enable) begin
          if (frame_cnt_q == DIV_LAST) begin
            frame_cnt_d = '0;
            state_d     = S_CALC_X;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      S_CALC_X: begin
        nx_d     = CORDW'(step_pos({1'b0, qx_q}, dir_x_q, XMAX));
        flip_x_d = step_flip({1'b0, qx_q}, dir_x_q, XMAX);
        state_d  = S_CALC_Y;
      end
      S_CALC_Y: begin
        // Both axes land in the same edge so the COMMIT cycle shows the new position.
        flip_y   = step_flip({1'b0, qy_q}, dir_y_q, YMAX);
        qy_d     = CORDW'(step_pos({1'b0, qy_q}, dir_y_q, YMAX));
        qx_d     = nx_q;
        dir_x_d  = dir_x_q ^ flip_x_q;
        dir_y_d  = dir_y_q ^ flip_y;
        bounce_d = flip_x_q | flip_y;
        state_d  = S_COMMIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_q      <= 1'b0;
      frame_cnt_q <= '0;
      qx_q        <= '0;
      qy_q        <= '0;
      nx_q        <= '0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      flip_x_q    <= 1'b0;
      bounce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= (sy == TICK_Y) && (sx == '0);
      frame_cnt_q <= frame_cnt_d;
      qx_q        <= qx_d;
      qy_q        <= qy_d;
      nx_q        <= nx_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      flip_x_q    <= flip_x_d;
      bounce_q    <= bounce_d;
    end
  end

  assign qx     = qx_q;
  assign qy     = qy_q;
  assign dir_x  = dir_x_q;
  assign dir_y  = dir_y_q;
  assign bounce = bounce_q;
  assign busy   = (state_q != S_IDLE);

`ifdef SQUARE_MOTION_DRAW_EN
  localparam logic [CORDW:0] QS = (CORDW+1)'(Q_SIZE);

  logic q_draw_q, q_draw_d;

  always_comb begin
    q_draw_d = ({1'b0, sx} >= {1'b0, qx_q}) && ({1'b0, sx} < {1'b0, qx_q} + QS) &&
               ({1'b0, sy} >= {1'b0, qy_q}) && ({1'b0, sy} < {1'b0, qy_q} + QS);
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) q_draw_q <= 1'b0;
    else        q_draw_q <= q_draw_d;
  end

  assign q_draw = q_draw_q;
`endif

endmodule
